// File: rtl/muon_decay_acq_ctrl.sv
// Muon-decay acquisition sequencer: arms the detector window, applies holdoff after each capture,
// queues delta-times in a fall-through FIFO and keeps run statistics. DECAY_TIMESTAMP_EN adds 32-bit entry timestamps.
module muon_decay_acq_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               run,
  input  logic               clear,
  input  logic [15:0]        cfg_window,
  input  logic [15:0]        cfg_holdoff,
  input  logic [31:0]        cfg_max_events,
  input  logic               single_pulse,
  input  logic               dp_double_trig,
  input  logic [15:0]        dp_delta,
  output logic [15:0]        dp_window,
`ifdef DECAY_TIMESTAMP_EN
  output logic [47:0]        evt_tdata,
`else
  output logic [15:0]        evt_tdata,
`endif
  output logic               evt_tvalid,
  input  logic               evt_tready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               done,
  output logic [31:0]        n_singles,
  output logic [31:0]        n_doubles,
  output logic [31:0]        n_dropped
);

  localparam int DEPTH = 2 ** FIFO_AW;
`ifdef DECAY_TIMESTAMP_EN
  localparam int DW = 48;
`else
  localparam int DW = 16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               run_q, trig_q, trig_prev_q;
  logic [15:0]        delta_q;
  logic [15:0]        win_q, win_d, hold_q, hold_d, hcnt_q, hcnt_d;
  logic [31:0]        cap_q, cap_d;
  logic [31:0]        n_singles_q, n_singles_d, n_doubles_q, n_doubles_d, n_dropped_q, n_dropped_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [DW-1:0]      mem_q [DEPTH];
  logic [DW-1:0]      entry;
  logic               capture, fifo_full, push, pop, active;
`ifdef DECAY_TIMESTAMP_EN
  logic [31:0]        ts_q, ts_d;
  assign entry = {ts_q, delta_q};
`else
  assign entry = delta_q;
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Trigger and run are registered, so a capture acts one edge after the detector edge is sampled.
  assign capture   = trig_q & ~trig_prev_q;
  // Occupancy never exceeds DEPTH, so the MSB alone marks full (pre-pop).
  assign fifo_full = level_q[FIFO_AW];
  assign pop       = (level_q != '0) & evt_tready;
  assign active    = (state_q == S_ARMED) || (state_q == S_HOLDOFF);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    hold_d      = hold_q;
    hcnt_d      = hcnt_q;
    cap_d       = cap_q;
    n_singles_d = n_singles_q;
    n_doubles_d = n_doubles_q;
    n_dropped_d = n_dropped_q;
    push        = 1'b0;
`ifdef DECAY_TIMESTAMP_EN
    ts_d        = ts_q + 32'd1;
`endif

    case (state_q)
      S_IDLE: begin
        if (run_q) begin
          win_d   = cfg_window;
          hold_d  = cfg_holdoff;
          cap_d   = '0;
          state_d = S_ARMED;
`ifdef DECAY_TIMESTAMP_EN
          ts_d    = '0;
`endif
        end
      end
      S_ARMED: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else if (capture) begin
          if (!fifo_full) begin
            push        = 1'b1;
            n_doubles_d = sat_inc(n_doubles_q);
            cap_d       = cap_q + 32'd1;
          end else begin
            n_dropped_d = sat_inc(n_dropped_q);
          end
          if ((cfg_max_events != '0) && (cap_d == cfg_max_events)) begin
            state_d = S_DONE;
          end else if (hold_q != '0) begin
            state_d = S_HOLDOFF;
            hcnt_d  = hold_q;
          end
        end
      end
      S_HOLDOFF: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q - 16'd1;
          if (hcnt_q == 16'd1) state_d = S_ARMED;
        end
      end
      S_DONE: begin
        if (!run_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (active && single_pulse) n_singles_d = sat_inc(n_singles_q);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;

    if (clear) begin
      state_d     = S_IDLE;
      hcnt_d      = '0;
      cap_d       = '0;
      n_singles_d = '0;
      n_doubles_d = '0;
      n_dropped_d = '0;
      push        = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
`ifdef DECAY_TIMESTAMP_EN
      ts_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      delta_q     <= '0;
      win_q       <= '0;
      hold_q      <= '0;
      hcnt_q      <= '0;
      cap_q       <= '0;
      n_singles_q <= '0;
      n_doubles_q <= '0;
      n_dropped_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
`ifdef DECAY_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run;
      trig_q      <= dp_double_trig;
      trig_prev_q <= trig_q;
      delta_q     <= dp_delta;
      win_q       <= win_d;
      hold_q      <= hold_d;
      hcnt_q      <= hcnt_d;
      cap_q       <= cap_d;
      n_singles_q <= n_singles_d;
      n_doubles_q <= n_doubles_d;
      n_dropped_q <= n_dropped_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
`ifdef DECAY_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  // Head is gated so stale storage never shows after reset or clear.
  assign evt_tvalid = (level_q != '0);
  assign evt_tdata  = evt_tvalid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign dp_window  = active ? win_q : 16'd0;
  assign busy       = active;
  assign done       = (state_q == S_DONE);
  assign n_singles  = n_singles_q;
  assign n_doubles  = n_doubles_q;
  assign n_dropped  = n_dropped_q;

endmodule

// File: tb/tb_muon_decay_acq_ctrl.sv
// Bench for muon_decay_acq_ctrl: hand-computed vector table, directed corner sequences,
// and randomized traffic checked each cycle against a queue-based reference model.
module tb_muon_decay_acq_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_HOLD = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        aresetn, run, clear, single_pulse, dp_double_trig, evt_tready;
  logic [15:0] cfg_window, cfg_holdoff, dp_delta;
  logic [31:0] cfg_max_events;
  logic [15:0] dp_window, evt_tdata;
  logic        evt_tvalid, busy, done;
  logic [AW:0] fifo_level;
  logic [31:0] n_singles, n_doubles, n_dropped;

  int total, bad;

  always #5 clk = ~clk;

  muon_decay_acq_ctrl #(.FIFO_AW(AW)) dut (
    .clk(clk), .aresetn(aresetn), .run(run), .clear(clear),
    .cfg_window(cfg_window), .cfg_holdoff(cfg_holdoff), .cfg_max_events(cfg_max_events),
    .single_pulse(single_pulse), .dp_double_trig(dp_double_trig), .dp_delta(dp_delta),
    .dp_window(dp_window), .evt_tdata(evt_tdata), .evt_tvalid(evt_tvalid),
    .evt_tready(evt_tready), .fifo_level(fifo_level), .busy(busy), .done(done),
    .n_singles(n_singles), .n_doubles(n_doubles), .n_dropped(n_dropped)
  );

  // Reference model: inputs as seen one edge earlier, an explicit event queue and plain counters.
  int          m_mode;
  bit          m_run_s, m_trig_s, m_trig_p;
  logic [15:0] m_delta_s, m_win, m_hold;
  int          m_left;
  longint      m_cap, m_ns, m_nd, m_ndr;
  logic [15:0] m_q[$];

  function automatic longint sat(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_run_s = 0; m_trig_s = 0; m_trig_p = 0; m_delta_s = 0;
    m_win = 0; m_hold = 0; m_left = 0; m_cap = 0; m_ns = 0; m_nd = 0; m_ndr = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit ev, full, pop;
    ev   = m_trig_s && !m_trig_p;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && evt_tready;
    if (clear) begin
      m_q.delete(); m_ns = 0; m_nd = 0; m_ndr = 0; m_cap = 0; m_mode = M_IDLE;
    end else begin
      if ((m_mode == M_ARMED || m_mode == M_HOLD) && single_pulse) m_ns = sat(m_ns);
      if (pop) void'(m_q.pop_front());
      case (m_mode)
        M_IDLE: if (m_run_s) begin
          m_win = cfg_window; m_hold = cfg_holdoff; m_cap = 0; m_mode = M_ARMED;
        end
        M_ARMED: if (!m_run_s) m_mode = M_IDLE;
        else if (ev) begin
          if (!full) begin m_q.push_back(m_delta_s); m_nd = sat(m_nd); m_cap++; end
          else m_ndr = sat(m_ndr);
          if (cfg_max_events != 0 && m_cap == longint'(cfg_max_events)) m_mode = M_DONE;
          else if (m_hold != 0) begin m_mode = M_HOLD; m_left = int'(m_hold); end
        end
        M_HOLD: if (!m_run_s) m_mode = M_IDLE;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_ARMED;
        end
        default: if (!m_run_s) m_mode = M_IDLE;
      endcase
    end
    m_run_s = run; m_trig_p = m_trig_s; m_trig_s = dp_double_trig; m_delta_s = dp_delta;
  endtask

  task automatic check_model();
    bit act_m;
    act_m = (m_mode == M_ARMED || m_mode == M_HOLD);
    chk("window", dp_window, act_m ? longint'(m_win) : 0);
    chk("tvalid", evt_tvalid, m_q.size() != 0);
    chk("tdata", evt_tdata, (m_q.size() != 0) ? longint'(m_q[0]) : 0);
    chk("level", fifo_level, m_q.size());
    chk("busy", busy, act_m);
    chk("done", done, m_mode == M_DONE);
    chk("n_singles", n_singles, m_ns);
    chk("n_doubles", n_doubles, m_nd);
    chk("n_dropped", n_dropped, m_ndr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic restart(input int hold, input int maxev);
    run = 0; clear = 1; tick(); clear = 0; tick();
    cfg_holdoff = 16'(hold); cfg_max_events = 32'(maxev); run = 1; tick(); tick();
  endtask

  task automatic pulse();
    dp_double_trig = 1; tick(); dp_double_trig = 0; tick(); tick();
  endtask

  typedef struct {
    bit run_i, trig_i; logic [15:0] delta_i; bit rdy_i;
    logic [15:0] win_e; bit vld_e; logic [15:0] dat_e; int lvl_e; int nd_e;
  } vec_t;
  vec_t tbl[8];

  initial begin
    total = 0; bad = 0;
    tbl[0] = '{1'b1, 1'b0, 16'd37, 1'b0, 16'd0,   1'b0, 16'd0,  0, 0};
    tbl[1] = '{1'b1, 1'b0, 16'd37, 1'b0, 16'd100, 1'b0, 16'd0,  0, 0};
    tbl[2] = '{1'b1, 1'b1, 16'd37, 1'b0, 16'd100, 1'b0, 16'd0,  0, 0};
    tbl[3] = '{1'b1, 1'b1, 16'd37, 1'b0, 16'd100, 1'b1, 16'd37, 1, 1};
    tbl[4] = '{1'b1, 1'b1, 16'd37, 1'b0, 16'd100, 1'b1, 16'd37, 1, 1};
    tbl[5] = '{1'b1, 1'b0, 16'd37, 1'b0, 16'd100, 1'b1, 16'd37, 1, 1};
    tbl[6] = '{1'b1, 1'b0, 16'd37, 1'b1, 16'd100, 1'b0, 16'd0,  0, 1};
    tbl[7] = '{1'b1, 1'b0, 16'd37, 1'b0, 16'd100, 1'b0, 16'd0,  0, 1};

    aresetn = 0; run = 0; clear = 0; single_pulse = 0; dp_double_trig = 0; evt_tready = 0;
    dp_delta = 0; cfg_window = 16'd100; cfg_holdoff = 0; cfg_max_events = 0;
    repeat (3) @(negedge clk);
    model_reset();
    aresetn = 1;
    #1;
    chk("rst_window", dp_window, 0);  chk("rst_tvalid", evt_tvalid, 0);
    chk("rst_tdata", evt_tdata, 0);   chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_singles", n_singles, 0); chk("rst_doubles", n_doubles, 0);
    chk("rst_dropped", n_dropped, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run = tbl[i].run_i; dp_double_trig = tbl[i].trig_i;
      dp_delta = tbl[i].delta_i; evt_tready = tbl[i].rdy_i;
      tick();
      chk($sformatf("vec%0d_window", i), dp_window, tbl[i].win_e);
      chk($sformatf("vec%0d_tvalid", i), evt_tvalid, tbl[i].vld_e);
      chk($sformatf("vec%0d_tdata", i), evt_tdata, tbl[i].dat_e);
      chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].lvl_e);
      chk($sformatf("vec%0d_doubles", i), n_doubles, tbl[i].nd_e);
    end

    // Holdoff 20: edges at 0, 10, 25; the middle one lands inside the dead time.
    restart(20, 0);
    for (int i = 0; i < 40; i++) begin
      dp_delta = 16'(100 + i);
      dp_double_trig = (i == 0 || i == 1 || i == 10 || i == 11 || i == 25 || i == 26);
      tick();
    end
    dp_double_trig = 0; tick();
    chk("hold_doubles", n_doubles, 2); chk("hold_dropped", n_dropped, 0);
    chk("hold_level", fifo_level, 2);  chk("hold_head1", evt_tdata, 100);
    evt_tready = 1; tick(); evt_tready = 0;
    chk("hold_head2", evt_tdata, 125);

    // Six captures into a four-deep FIFO, then one more while a pop happens.
    restart(0, 0);
    for (int p = 0; p < 6; p++) begin dp_delta = 16'(p); pulse(); end
    chk("fill_level", fifo_level, 4); chk("fill_dropped", n_dropped, 2);
    chk("fill_doubles", n_doubles, 4);
    dp_double_trig = 1; tick(); dp_double_trig = 0; evt_tready = 1; tick(); evt_tready = 0; tick();
    chk("fullpop_dropped", n_dropped, 3); chk("fullpop_level", fifo_level, 3);
    chk("fullpop_head", evt_tdata, 1);

    // Stop after three events.
    restart(0, 3);
    evt_tready = 1;
    repeat (3) pulse();
    chk("max_done", done, 1); chk("max_window", dp_window, 0); chk("max_doubles", n_doubles, 3);
    pulse();
    chk("max_extra", n_doubles, 3);
    run = 0; tick(); tick();
    chk("max_idle", done, 0);
    evt_tready = 0; cfg_max_events = 0;

    // Capture coincident with run falling is discarded.
    restart(0, 0);
    dp_double_trig = 1; run = 0; tick(); dp_double_trig = 0; tick(); tick();
    chk("runfall_doubles", n_doubles, 0); chk("runfall_level", fifo_level, 0);

    // Clear while armed.
    restart(0, 0);
    pulse(); pulse();
    chk("preclr_doubles", n_doubles, 2);
    clear = 1; tick(); clear = 0;
    chk("clr_doubles", n_doubles, 0); chk("clr_level", fifo_level, 0);
    chk("clr_busy", busy, 0);         chk("clr_tvalid", evt_tvalid, 0);

    // Singles counted only while armed/holdoff.
    run = 0; clear = 1; tick(); clear = 0; tick(); tick();
    repeat (5) begin single_pulse = 1; tick(); single_pulse = 0; tick(); end
    chk("singles_idle", n_singles, 0);
    run = 1; tick(); tick();
    repeat (7) begin single_pulse = 1; tick(); single_pulse = 0; tick(); end
    chk("singles_armed", n_singles, 7);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      clear          = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) dp_double_trig = ~dp_double_trig;
      dp_delta       = 16'($urandom);
      evt_tready     = ($urandom_range(0, 2) == 0);
      single_pulse   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) begin
        cfg_window     = 16'($urandom);
        cfg_holdoff    = 16'($urandom_range(0, 6));
        cfg_max_events = 32'($urandom_range(0, 8));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muon_decay_acq_ctrl.md
# muon_decay_acq_ctrl

Acquisition sequencer for the muon-decay double-pulse trigger path. It arms and disarms the double-pulse detector by driving its window. It applies a programmable dead time after each decay. Captured delta-times go into a FIFO with valid/ready readout toward the PS/DMA side. It also maintains run statistics, so the detector can be shared across acquisition runs without software re-timing.

## Interface
Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- run  in  1  level; acquisition enable.
- clear  in  1  one-cycle pulse; flushes FIFO, zeroes counters, forces IDLE.
- cfg_window  in  16  decay window (cycles); sampled on IDLE->ARMED.
- cfg_holdoff  in  16  dead time after each capture (cycles); sampled on IDLE->ARMED.
- cfg_max_events  in  32  stop after this many captured events; 0 = unlimited.
- single_pulse  in  1  one-cycle strobe per detected first pulse.
- dp_double_trig  in  1  level from detector; high from decay detection until window expiry.
- dp_delta  in  16  detector delta-time, valid when dp_double_trig is high.
- dp_window  out  16  window driven to detector; 0 (detector disabled) unless ARMED or HOLDOFF.
- evt_tdata  out  16 (48 with macro)  FIFO head.
- evt_tvalid  out  1  FIFO non-empty.
- evt_tready  in  1  consumer pop; pop occurs when tvalid & tready.
- fifo_level  out  FIFO_AW+1  entries held.
- busy  out  1  state is ARMED or HOLDOFF.
- done  out  1  state is DONE.
- n_singles, n_doubles, n_dropped  out  32 each  run statistics, saturating at 0xFFFFFFFF.

## Operation
- States: IDLE, ARMED, HOLDOFF, DONE.
- Capture event: rising edge of dp_double_trig. The block keeps a registered copy of the previous value; the event is cur & ~prev.
- IDLE:
  - dp_window = 0.
  - When run = 1: latch win_reg = cfg_window and hold_reg = cfg_holdoff, then go to ARMED.
- ARMED:
  - dp_window = win_reg.
  - On a capture event, if the FIFO is not full: push dp_delta and increment n_doubles and the captured count.
  - On a capture event with the FIFO full: increment n_dropped; no push.
  - After the event, go to DONE if cfg_max_events ≠ 0 and captured count == cfg_max_events. Otherwise go to HOLDOFF if hold_reg ≠ 0. Otherwise stay in ARMED.
- HOLDOFF:
  - dp_window = win_reg.
  - A down-counter loads hold_reg on entry; the block returns to ARMED when it reaches 0. Total dead time is hold_reg cycles.
  - Capture events are ignored and not counted.
- DONE: holds until run = 0, then goes to IDLE. FIFO remains readable.
- In ARMED or HOLDOFF, run = 0 returns the block to IDLE.
- n_singles increments on single_pulse in ARMED or HOLDOFF only.
- Priority, highest first: clear, run deassertion, capture event. A capture coincident with run falling is discarded.
- FIFO full test uses pre-pop occupancy. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- On an empty FIFO, a simultaneous push and pop is impossible (tvalid = 0).
- Counters and FIFO persist across runs; only clear or reset zeroes them. The captured count zeroes on every IDLE->ARMED transition.

## Timing
- Reset values: state IDLE; dp_window 0; evt_tvalid 0; evt_tdata 0; fifo_level 0; busy 0; done 0; all counters 0.
- run sampled high at edge k: ARMED and dp_window valid after edge k+1.
- dp_double_trig first sampled high at edge N:
  - Entry written and counters updated at N+1.
  - evt_tvalid high after N+1 if the FIFO was empty (first-word fall-through, 1-cycle latency).
- Pop at edge P: next head or tvalid = 0 visible after P.
- HOLDOFF entered at N+1 lasts exactly hold_reg cycles.
- DONE and done asserted at N+1 for the final event.
- clear takes effect at the next edge; its outputs match the reset values.

## Configuration
- DECAY_TIMESTAMP_EN defined:
  - Adds a 32-bit cycle counter, zeroed on IDLE->ARMED and wrapping at 2^32.
  - Each FIFO entry is {timestamp[31:0], dp_delta[15:0]}, timestamped at the capture edge; evt_tdata is 48 bits.
- DECAY_TIMESTAMP_EN undefined: no timestamp logic; entries and evt_tdata are 16 bits.

## Test plan
- Reset, then run = 1, cfg_window = 100, holdoff 0; drive dp_double_trig high with dp_delta = 37 -> evt_tdata = 37 and tvalid one cycle after; n_doubles = 1; dp_window = 100.
- Holdoff 20: two rising edges 10 cycles apart, then a third 25 cycles after the first -> entries 1 and 3 captured, second ignored, n_doubles = 2, n_dropped = 0.
- FIFO_AW = 2, tready = 0: six captures -> fifo_level = 4, n_dropped = 2. Capture on full with a simultaneous pop -> still dropped.
- cfg_max_events = 3: after the third capture -> done = 1 and dp_window = 0; further edges not counted. run low -> IDLE.
- run falling on the same edge as a capture -> no push, n_doubles unchanged. clear mid-ARMED -> counters 0, fifo_level 0, IDLE.
- single_pulse ×5 in IDLE and ×7 while armed -> n_singles = 7.
